// File: rtl/map_bank_pkg.sv
// Shared constants and width helpers for the banked-ROM mapper.
package map_bank_pkg;

    localparam logic [7:0] A130_BASE_LO = 8'hF0;
    localparam int         CTRL_IDX     = 0;
    localparam int         LOCK_BIT     = 0;

    function automatic int off_w(input int slot_bits);
        return 22 - slot_bits;
    endfunction

    function automatic int rom_aw(input int slot_bits, input int bank_w);
        return 22 - slot_bits + bank_w;
    endfunction

endpackage

// File: rtl/map_bank_led_act.sv
// Activity LED: free-running idle blink ORed with a stretched pulse per register write.
module led_act #(
    parameter int LED_DIV = 26,
    parameter int ACT_W   = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic led
);

    logic [LED_DIV-1:0] ctr_q, ctr_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic               led_q, led_d;

    // A pulse reloads the stretch even while one is already running.
    always_comb begin
        ctr_d = ctr_q + LED_DIV'(1);
        act_d = act_q;
        if (pulse)
            act_d = '1;
        else if (act_q != '0)
            act_d = act_q - ACT_W'(1);
        led_d = (act_d != '0) | ctr_d[LED_DIV-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= '0;
            act_q <= '0;
            led_q <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            act_q <= act_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/map_bank.sv
// Banked-ROM mapper: slot 0 fixed, other slots remapped via /TIME registers with a sticky lock.
module map_bank
    import map_bank_pkg::*;
#(
    parameter int SLOT_BITS = 3,
    parameter int BANK_W    = 6,
    parameter int LED_DIV   = 26,
    parameter int ACT_W     = 22
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [23:0]                           cpu_addr,
    input  logic [15:0]                           cpu_data,
    input  logic                                  cpu_ce_lo,
    input  logic                                  cpu_oe,
    input  logic                                  cpu_we_lo,
    input  logic                                  cpu_tim,
    input  logic [15:0]                           rom_do,
    output logic [rom_aw(SLOT_BITS, BANK_W)-1:0]  rom_addr,
    output logic                                  rom_oe,
    output logic                                  map_oe,
    output logic [15:0]                           map_do,
    output logic                                  led_r,
    output logic                                  mask_off,
    output logic                                  map_nsp
);

    localparam int OFF_W = off_w(SLOT_BITS);
    localparam int NSLOT = 1 << SLOT_BITS;

    logic [SLOT_BITS-1:0] slot, idx;
    logic [BANK_W-1:0]    bank_q [NSLOT];
    logic [BANK_W-1:0]    bank_d [NSLOT];
    logic                 lock_q, lock_d;
    logic                 we_q, we_d;
    logic                 hit, wr_pulse;
    logic                 unused_bits;

    assign slot     = cpu_addr[21:OFF_W];
    assign idx      = cpu_addr[SLOT_BITS:1];
    assign hit      = !cpu_tim && cpu_addr[0] && (&cpu_addr[7:SLOT_BITS+1]);
    assign wr_pulse = we_q && !cpu_we_lo && hit;

    always_comb begin
        we_d      = cpu_we_lo;
        lock_d    = lock_q;
        bank_d    = bank_q;
        bank_d[0] = '0;
        if (wr_pulse) begin
            if (idx == SLOT_BITS'(CTRL_IDX))
                lock_d = lock_q | cpu_data[LOCK_BIT];
            else if (!lock_q)
                bank_d[idx] = cpu_data[BANK_W-1:0];
        end
    end

    // Reset wins over a pending write and restores the identity mapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            lock_q <= 1'b0;
            for (int k = 0; k < NSLOT; k++)
                bank_q[k] <= BANK_W'(k);
        end else begin
            we_q   <= we_d;
            lock_q <= lock_d;
            bank_q <= bank_d;
        end
    end

    assign rom_addr = {bank_q[slot], cpu_addr[OFF_W-1:0]};
    assign rom_oe   = !cpu_ce_lo && !cpu_oe;
    assign map_oe   = !cpu_ce_lo && !cpu_oe;
    assign map_do   = rom_do;
    assign mask_off = 1'b1;
    assign map_nsp  = 1'b0;

    assign unused_bits = ^{cpu_addr[23:22], cpu_data};

    led_act #(
        .LED_DIV (LED_DIV),
        .ACT_W   (ACT_W)
    ) u_led (
        .clk   (clk),
        .rst   (rst),
        .pulse (wr_pulse),
        .led   (led_r)
    );

endmodule

// File: tb/tb_map_bank.sv
// Randomized plus directed bench for map_bank against a cycle-count reference model.
module tb_map_bank;

    localparam int SB  = 3;
    localparam int BW  = 6;
    localparam int LD  = 4;
    localparam int AW  = 3;
    localparam int OFF = 22 - SB;
    localparam int RAW = OFF + BW;

    logic           clk = 1'b0;
    logic           rst;
    logic [23:0]    cpu_addr;
    logic [15:0]    cpu_data, rom_do, map_do;
    logic           cpu_ce_lo, cpu_oe, cpu_we_lo, cpu_tim;
    logic [RAW-1:0] rom_addr;
    logic           rom_oe, map_oe, led_r, mask_off, map_nsp;

    always #5 clk = ~clk;

    map_bank #(.SLOT_BITS(SB), .BANK_W(BW), .LED_DIV(LD), .ACT_W(AW)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ce_lo(cpu_ce_lo), .cpu_oe(cpu_oe), .cpu_we_lo(cpu_we_lo),
        .cpu_tim(cpu_tim), .rom_do(rom_do), .rom_addr(rom_addr),
        .rom_oe(rom_oe), .map_oe(map_oe), .map_do(map_do), .led_r(led_r),
        .mask_off(mask_off), .map_nsp(map_nsp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: bank table, lock, last sampled strobe, edges since reset, edge of last write
    int m_bank [8];
    bit m_lock;
    bit m_prev_we;
    int m_e;
    int m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic bit m_led();
        bit blink, stretch;
        blink   = (m_e % (1 << LD)) >= (1 << (LD - 1));
        stretch = (m_last >= 0) && (m_e - m_last < (1 << AW) - 1);
        return blink || stretch;
    endfunction

    task automatic check_outputs();
        int s;
        s = int'(cpu_addr[21:19]);
        chk("rom_addr", 32'(rom_addr), 32'(m_bank[s] * (1 << OFF) + int'(cpu_addr[18:0])));
        chk("rom_oe",   32'(rom_oe),   32'(!cpu_ce_lo && !cpu_oe));
        chk("map_oe",   32'(map_oe),   32'(!cpu_ce_lo && !cpu_oe));
        chk("map_do",   32'(map_do),   32'(rom_do));
        chk("led_r",    32'(led_r),    32'(m_led()));
        chk("mask_off", 32'(mask_off), 32'd1);
        chk("map_nsp",  32'(map_nsp),  32'd0);
    endtask

    task automatic model_edge();
        bit hit, pulse;
        int idx;
        if (rst) begin
            for (int k = 0; k < 8; k++) m_bank[k] = k;
            m_lock = 0; m_prev_we = 0; m_e = 0; m_last = -100;
            return;
        end
        hit   = !cpu_tim && (cpu_addr[7:0] & 8'hF1) == 8'hF1;
        pulse = m_prev_we && !cpu_we_lo && hit;
        idx   = int'(cpu_addr[3:1]);
        m_e++;
        if (pulse) begin
            m_last = m_e;
            if (idx == 0) m_lock = m_lock | cpu_data[0];
            else if (!m_lock) m_bank[idx] = int'(cpu_data[5:0]);
        end
        m_prev_we = cpu_we_lo;
    endtask

    bit armed = 0;

    task automatic cyc();
        @(negedge clk);
        if (armed) check_outputs();
        @(posedge clk);
        model_edge();
        armed = 1;
        #1;
    endtask

    task automatic idle();
        cpu_we_lo = 1; cpu_tim = 1; cpu_ce_lo = 1; cpu_oe = 1;
    endtask

    task automatic do_reset();
        rst = 1; cyc(); rst = 0;
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d);
        cpu_addr = a; cpu_data = d; cpu_tim = 0; cpu_we_lo = 0; cyc();
        cpu_we_lo = 1; cpu_tim = 1; cyc();
    endtask

    task automatic rd(input logic [23:0] a, input string tag, input logic [31:0] exp);
        cpu_addr = a; cpu_ce_lo = 0; cpu_oe = 0; #1;
        chk(tag, 32'(rom_addr), exp);
        chk({tag, "_oe"}, 32'({rom_oe, map_oe}), 32'd3);
        cyc();
        cpu_ce_lo = 1; cpu_oe = 1;
    endtask

    initial begin
        cpu_addr = '0; cpu_data = '0; rom_do = 16'h1234;
        idle();
        rst = 1;
        @(posedge clk); model_edge(); #1;
        cyc();
        rst = 0;
        cyc();

        // Boot read is identity-mapped
        rd(24'h080000, "t1_ra", 32'h080000);

        // Single bank write, visible next cycle
        wr(24'hA130F5, 16'h002A);
        rd(24'h100004, "t2_ra", 32'h1500004);

        // Held strobe captures only the first data value
        cpu_addr = 24'hA130F3; cpu_tim = 0; cpu_data = 16'h0005; cpu_we_lo = 0; cyc();
        cpu_data = 16'h0009;
        repeat (9) cyc();
        idle(); cyc();
        rd(24'h080000, "t3_ra", 32'h280000);

        // Lock is sticky and drops bank writes
        wr(24'hA130F1, 16'h0001);
        wr(24'hA130F3, 16'h003F);
        rd(24'h080000, "t4_locked", 32'h280000);
        wr(24'hA130F1, 16'h0000);
        wr(24'hA130F3, 16'h003F);
        rd(24'h080000, "t4_still", 32'h280000);
        do_reset(); cyc();
        rd(24'h080000, "t4_rst1", 32'h080000);
        rd(24'h100004, "t4_rst2", 32'h100004);

        // Reset mid-strobe discards the write; a fresh strobe is needed
        cpu_addr = 24'hA130F7; cpu_tim = 0; cpu_data = 16'h0011; cpu_we_lo = 0;
        rst = 1; cyc(); rst = 0;
        cyc(); cyc();
        cpu_tim = 1;
        rd(24'h180000, "t5_drop", 32'h180000);
        idle(); cyc();
        wr(24'hA130F7, 16'h0011);
        rd(24'h180000, "t5_new", 32'h880000);

        // Idle blink, single stretch ending at edge 23, reloaded stretch covering it
        idle(); do_reset();
        for (int k = 1; k <= 15; k++) begin
            cyc(); chk("t6_blink", 32'(led_r), 32'((k % 16) >= 8));
        end
        cpu_addr = 24'hA130F1; cpu_data = 16'h0000; cpu_tim = 0; cpu_we_lo = 0; cyc();
        chk("t6_on", 32'(led_r), 32'd1);
        idle();
        for (int k = 17; k <= 24; k++) begin
            cyc(); chk("t6_stretch", 32'(led_r), 32'((k <= 22) || (k >= 24)));
        end
        do_reset();
        repeat (15) cyc();
        cpu_addr = 24'hA130F1; cpu_data = 16'h0000; cpu_tim = 0; cpu_we_lo = 0; cyc();
        cpu_we_lo = 1; cyc();
        cpu_we_lo = 0; cyc();
        idle();
        repeat (5) cyc();
        chk("t6_reload", 32'(led_r), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) cpu_we_lo = ~cpu_we_lo;
            if ($urandom_range(0, 1) == 0) begin
                cpu_addr = {16'hA130, 4'hF, 4'($urandom_range(0, 15))};
                cpu_tim  = ($urandom_range(0, 5) == 0);
            end else begin
                cpu_addr = 24'($urandom);
                cpu_tim  = 1'($urandom);
            end
            cpu_data = 16'($urandom);
            if (cpu_addr[3:1] == 3'd0) cpu_data[0] = ($urandom_range(0, 7) == 0);
            cpu_ce_lo = 1'($urandom);
            cpu_oe    = 1'($urandom);
            rom_do    = 16'($urandom);
            cyc();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
